// File: rtl/pixel_frame_seq.sv
// ---------------------------------------------------------------------------
// pixel_frame_seq
// Read-side sequencer for the pixel async FIFO. Pops show-ahead FIFO data
// into a single output register and presents it as a valid/ready pixel
// stream tagged with start-of-frame, end-of-line and end-of-frame flags.
// A frame is started with a start pulse (dimensions sampled then) and may be
// cut short with a stop pulse. Starved read cycles are counted.
//
// Ports:
//   clk, rst          read-domain clock, asynchronous active-high reset
//   start, stop       one-cycle control pulses
//   cfg_width/height  frame size, sampled on an accepted start
//   fifo_empty        FIFO empty flag
//   fifo_rd_data      show-ahead FIFO data
//   fifo_rd_en        FIFO pop strobe (combinational)
//   out_valid/ready   output handshake
//   out_data          pixel
//   out_sof/eol/eof   frame position flags
//   busy              sequencer not idle
//   frame_done        pulse: frame fully delivered
//   aborted           pulse: frame ended by stop
//   cfg_err           pulse: start rejected (zero dimension)
//   stall_cnt         saturating count of starved RUN cycles
// ---------------------------------------------------------------------------
module pixel_frame_seq #(
    parameter int DATA_WIDTH  = 8,
    parameter int DIM_WIDTH   = 12,
    parameter int STALL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [DIM_WIDTH-1:0]   cfg_width,
    input  logic [DIM_WIDTH-1:0]   cfg_height,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    output logic                   fifo_rd_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_sof,
    output logic                   out_eol,
    output logic                   out_eof,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   aborted,
    output logic                   cfg_err,
    output logic [STALL_WIDTH-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    localparam logic [DIM_WIDTH-1:0]   DIM_ZERO   = {DIM_WIDTH{1'b0}};
    localparam logic [DIM_WIDTH-1:0]   DIM_ONE    = {{(DIM_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STALL_WIDTH-1:0] STALL_ZERO = {STALL_WIDTH{1'b0}};
    localparam logic [STALL_WIDTH-1:0] STALL_ONE  = {{(STALL_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STALL_WIDTH-1:0] STALL_MAX  = {STALL_WIDTH{1'b1}};

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DIM_WIDTH-1:0]    r_width;
    logic [DIM_WIDTH-1:0]    r_height;
    logic [DIM_WIDTH-1:0]    r_col;
    logic [DIM_WIDTH-1:0]    r_row;
    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_out_sof;
    logic                    r_out_eol;
    logic                    r_out_eof;
    logic                    r_busy;
    logic                    r_frame_done;
    logic                    r_aborted;
    logic                    r_cfg_err;
    logic [STALL_WIDTH-1:0]  r_stall_cnt;

    logic w_out_free;
    logic w_pop;
    logic w_last_col;
    logic w_last_row;
    logic w_dims_ok;
    logic w_start_ok;
    logic w_done_nxt;
    logic w_abort_nxt;
    logic w_cfg_err_nxt;

    // The output register can take a new pixel if it is empty or draining now.
    assign w_out_free = !r_out_valid || out_ready;
    assign w_pop      = (r_state == S_RUN) && !fifo_empty && w_out_free;
    assign w_last_col = (r_col == (r_width - DIM_ONE));
    assign w_last_row = (r_row == (r_height - DIM_ONE));
    assign w_dims_ok  = (cfg_width != DIM_ZERO) && (cfg_height != DIM_ZERO);

    assign fifo_rd_en = w_pop;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_sof    = r_out_sof;
    assign out_eol    = r_out_eol;
    assign out_eof    = r_out_eof;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign aborted    = r_aborted;
    assign cfg_err    = r_cfg_err;
    assign stall_cnt  = r_stall_cnt;

    // Next-state and pulse decode; stop outranks start and frame completion.
    always_comb begin
        w_state_nxt   = r_state;
        w_start_ok    = 1'b0;
        w_done_nxt    = 1'b0;
        w_abort_nxt   = 1'b0;
        w_cfg_err_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    if (w_dims_ok) begin
                        w_state_nxt = S_RUN;
                        w_start_ok  = 1'b1;
                    end else begin
                        w_cfg_err_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_ABORT;
                end else if (w_pop && w_last_col && w_last_row) begin
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_FLUSH: begin
                if (stop) begin
                    w_state_nxt = S_ABORT;
                end else if (w_out_free) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_ABORT: begin
                if (w_out_free) begin
                    w_state_nxt = S_IDLE;
                    w_abort_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_ABORT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and registered status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_aborted    <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_frame_done <= w_done_nxt;
            r_aborted    <= w_abort_nxt;
            r_cfg_err    <= w_cfg_err_nxt;
        end
    end

    // Frame dimensions and column/row position of the next pixel to pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_width  <= DIM_ZERO;
            r_height <= DIM_ZERO;
            r_col    <= DIM_ZERO;
            r_row    <= DIM_ZERO;
        end else if (w_start_ok) begin
            r_width  <= cfg_width;
            r_height <= cfg_height;
            r_col    <= DIM_ZERO;
            r_row    <= DIM_ZERO;
        end else if (w_pop) begin
            if (w_last_col) begin
                r_col <= DIM_ZERO;
                r_row <= r_row + DIM_ONE;
            end else begin
                r_col <= r_col + DIM_ONE;
            end
        end
    end

    // Single-entry output register; flags come from the pre-increment position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {DATA_WIDTH{1'b0}};
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
            r_out_eof   <= 1'b0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_data  <= fifo_rd_data;
            r_out_sof   <= (r_col == DIM_ZERO) && (r_row == DIM_ZERO);
            r_out_eol   <= w_last_col;
            r_out_eof   <= w_last_col && w_last_row;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
            r_out_eof   <= 1'b0;
        end
    end

    // Starvation counter: RUN cycles where a pop was possible but FIFO was empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= STALL_ZERO;
        end else if (w_start_ok) begin
            r_stall_cnt <= STALL_ZERO;
        end else if ((r_state == S_RUN) && fifo_empty && w_out_free
                     && (r_stall_cnt != STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + STALL_ONE;
        end
    end

endmodule

// File: tb/tb_pixel_frame_seq.sv
module tb_pixel_frame_seq;

    localparam int DW = 8;
    localparam int MW = 12;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [MW-1:0] cfg_width = '0;
    logic [MW-1:0] cfg_height = '0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_en;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_sof, out_eol, out_eof;
    logic          busy, frame_done, aborted, cfg_err;
    logic [SW-1:0] stall_cnt;

    pixel_frame_seq #(.DATA_WIDTH(DW), .DIM_WIDTH(MW), .STALL_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .busy(busy), .frame_done(frame_done), .aborted(aborted),
        .cfg_err(cfg_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model: writes from the stimulus, pops on fifo_rd_en.
    logic [7:0] mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       flush_req = 1'b0;

    assign fifo_empty   = (rd_ptr == wr_ptr);
    assign fifo_rd_data = mem[rd_ptr[7:0]];

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) rd_ptr <= rd_ptr + 1;
        else if (flush_req)            rd_ptr <= wr_ptr;
    end

    // Monitor at the falling edge: the handshake seen here completes at the next rising edge.
    int         cyc = 0;
    int         pop_cnt = 0, held_pop = 0, empty_pop = 0;
    int         beat_cnt = 0, done_cnt = 0, abort_cnt = 0, cfgerr_cnt = 0;
    int         busy_cyc = 0, busy_bad = 0, hold_bad = 0;
    logic [10:0] beat_word [0:127];
    int          beat_cyc  [0:127];
    logic        prev_held = 1'b0;
    logic [10:0] prev_word = '0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (prev_held && (!out_valid || {out_sof, out_eol, out_eof, out_data} != prev_word))
                hold_bad = hold_bad + 1;
            if (fifo_rd_en) pop_cnt = pop_cnt + 1;
            if (fifo_rd_en && fifo_empty) empty_pop = empty_pop + 1;
            if (fifo_rd_en && out_valid && !out_ready) held_pop = held_pop + 1;
            if (out_valid && out_ready) begin
                beat_word[beat_cnt[6:0]] = {out_sof, out_eol, out_eof, out_data};
                beat_cyc[beat_cnt[6:0]]  = cyc;
                beat_cnt = beat_cnt + 1;
            end
            if (frame_done) begin
                done_cnt = done_cnt + 1;
                if (busy) busy_bad = busy_bad + 1;
            end
            if (aborted) abort_cnt = abort_cnt + 1;
            if (cfg_err) cfgerr_cnt = cfgerr_cnt + 1;
            if (busy) busy_cyc = busy_cyc + 1;
        end
        prev_held = out_valid && !out_ready && !rst;
        prev_word = {out_sof, out_eol, out_eof, out_data};
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[7:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic flush_fifo();
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
    endtask

    // Waits for frame_done or aborted; optionally toggles out_ready each cycle.
    task automatic wait_end(input int max_cyc, input bit toggle_ready);
        int base;
        int n;
        base = done_cnt + abort_cnt;
        n = 0;
        while ((done_cnt + abort_cnt) == base && n < max_cyc) begin
            @(posedge clk); #1;
            if (toggle_ready) out_ready = ~out_ready;
            n++;
        end
        check_eq("end_timeout", {31'd0, (done_cnt + abort_cnt) != base}, 32'd1);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Expected beat words from a raster model of the frame.
    task automatic check_beats(input int base, input int n, input int first, input int w, input int h);
        for (int i = 0; i < n; i++) begin
            int          col;
            int          row;
            logic [10:0] exp;
            col = i % w;
            row = i / w;
            exp[7:0] = 8'(first + i);
            exp[10]  = (col == 0) && (row == 0);
            exp[9]   = (col == w - 1);
            exp[8]   = (col == w - 1) && (row == h - 1);
            check_eq($sformatf("beat%0d", i), {21'd0, beat_word[(base + i) % 128]}, {21'd0, exp});
        end
    endtask

    int b_beat, b_pop, b_done, b_abort, b_cfg, b_busy, b_held, b_hold;

    task automatic snap();
        b_beat = beat_cnt; b_pop = pop_cnt; b_done = done_cnt; b_abort = abort_cnt;
        b_cfg = cfgerr_cnt; b_busy = busy_cyc; b_held = held_pop; b_hold = hold_bad;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_data", {24'd0, out_data}, 32'd0);
        check_eq("rst_stall", {16'd0, stall_cnt}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_rd_en", {31'd0, fifo_rd_en}, 32'd0);

        // 4x2 frame, full throughput
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        cfg_width = 12'd4; cfg_height = 12'd2; out_ready = 1'b1;
        snap();
        pulse_start();
        wait_end(50, 1'b0);
        check_eq("t1_beats", beat_cnt - b_beat, 32'd8);
        check_beats(b_beat, 8, 8'h10, 4, 2);
        check_eq("t1_back2back", beat_cyc[(b_beat + 7) % 128] - beat_cyc[b_beat % 128], 32'd7);
        check_eq("t1_pops", pop_cnt - b_pop, 32'd8);
        check_eq("t1_done", done_cnt - b_done, 32'd1);
        check_eq("t1_busy_at_done", busy_bad, 32'd0);
        check_eq("t1_stall", {16'd0, stall_cnt}, 32'd0);
        check_eq("t1_busy_after", {31'd0, busy}, 32'd0);

        // 4x2 frame, out_ready toggling; cfg changes mid-frame must not matter
        for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
        cfg_width = 12'd4; cfg_height = 12'd2; out_ready = 1'b1;
        snap();
        pulse_start();
        cfg_width = 12'd2; cfg_height = 12'd5;
        wait_end(100, 1'b1);
        check_eq("t2_beats", beat_cnt - b_beat, 32'd8);
        check_beats(b_beat, 8, 8'h20, 4, 2);
        check_eq("t2_pops", pop_cnt - b_pop, 32'd8);
        check_eq("t2_pop_while_held", held_pop - b_held, 32'd0);
        check_eq("t2_hold_stable", hold_bad - b_hold, 32'd0);
        check_eq("t2_done", done_cnt - b_done, 32'd1);

        // 3x1 frame with the FIFO starved for 5 cycles
        cfg_width = 12'd3; cfg_height = 12'd1; out_ready = 1'b1;
        snap();
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) push(8'(8'h30 + i));
        wait_end(50, 1'b0);
        check_eq("t3_stall", {16'd0, stall_cnt}, 32'd5);
        check_eq("t3_beats", beat_cnt - b_beat, 32'd3);
        check_beats(b_beat, 3, 8'h30, 3, 1);
        check_eq("t3_done", done_cnt - b_done, 32'd1);

        // zero width rejected; start together with stop ignored
        push(8'h55);
        cfg_width = 12'd0; cfg_height = 12'd2;
        snap();
        pulse_start();
        check_eq("t4_cfg_err_pulse", {31'd0, cfg_err}, 32'd1);
        @(posedge clk); #1;
        check_eq("t4_cfg_err_low", {31'd0, cfg_err}, 32'd0);
        cfg_width = 12'd2; cfg_height = 12'd2;
        stop = 1'b1;
        pulse_start();
        stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("t4_cfg_err_count", cfgerr_cnt - b_cfg, 32'd1);
        check_eq("t4_busy_cycles", busy_cyc - b_busy, 32'd0);
        check_eq("t4_pops", pop_cnt - b_pop, 32'd0);
        check_eq("t4_done", done_cnt - b_done, 32'd0);
        flush_fifo();

        // 8x8 frame aborted after the 5th pop while the output is held
        for (int i = 0; i < 64; i++) push(8'(8'h40 + i));
        cfg_width = 12'd8; cfg_height = 12'd8; out_ready = 1'b1;
        snap();
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("t5_held_valid", {31'd0, out_valid}, 32'd1);
        check_eq("t5_held_data", {24'd0, out_data}, 32'h44);
        check_eq("t5_busy", {31'd0, busy}, 32'd1);
        check_eq("t5_no_early_abort", abort_cnt - b_abort, 32'd0);
        out_ready = 1'b1;
        wait_end(20, 1'b0);
        check_eq("t5_beats", beat_cnt - b_beat, 32'd5);
        check_beats(b_beat, 5, 8'h40, 8, 8);
        check_eq("t5_pops", pop_cnt - b_pop, 32'd5);
        check_eq("t5_aborted", abort_cnt - b_abort, 32'd1);
        check_eq("t5_no_done", done_cnt - b_done, 32'd0);
        check_eq("t5_fifo_left", wr_ptr - rd_ptr, 32'd59);
        flush_fifo();

        // 1x1 frame with start held into RUN
        push(8'h60); push(8'h61);
        cfg_width = 12'd1; cfg_height = 12'd1; out_ready = 1'b1;
        snap();
        start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_end(20, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t6_beats", beat_cnt - b_beat, 32'd1);
        check_beats(b_beat, 1, 8'h60, 1, 1);
        check_eq("t6_done", done_cnt - b_done, 32'd1);
        check_eq("t6_pops", pop_cnt - b_pop, 32'd1);
        check_eq("t6_fifo_left", wr_ptr - rd_ptr, 32'd1);
        check_eq("t6_idle", {31'd0, busy}, 32'd0);
        flush_fifo();

        // reset mid-frame drops the pending pixel
        for (int i = 0; i < 4; i++) push(8'(8'h70 + i));
        cfg_width = 12'd4; cfg_height = 12'd1; out_ready = 1'b0;
        pulse_start();
        @(posedge clk); #1;
        check_eq("t7_pending", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("t7_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("t7_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("t7_rst_data", {24'd0, out_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        flush_fifo();

        check_eq("never_pop_empty", empty_pop, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_frame_seq.md
Name: pixel_frame_seq

Overview:
- Read-side sequencer for the pixel async FIFO.
- Pops show-ahead FIFO data and frames it into a valid/ready pixel stream for the processing stage.
- Marks each pixel with start-of-frame, end-of-line and end-of-frame flags, counting columns and rows against a programmed frame size.
- Supports start/stop control, reports busy/done/abort, and counts read-side starvation cycles.

Parameters:
DATA_WIDTH, 8, pixel width; must match the FIFO data width.
DIM_WIDTH, 12, width of the frame-dimension config and column/row counters.
STALL_WIDTH, 16, width of the saturating stall counter.

Ports:
clk  input  1  read-domain clock (same clock as the FIFO read side)
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begin one frame
stop  input  1  one-cycle pulse; abort the current frame
cfg_width  input  DIM_WIDTH  pixels per line; sampled on accepted start
cfg_height  input  DIM_WIDTH  lines per frame; sampled on accepted start
fifo_empty  input  1  FIFO empty flag
fifo_rd_data  input  DATA_WIDTH  FIFO show-ahead data; valid whenever !fifo_empty
fifo_rd_en  output  1  FIFO pop strobe (combinational)
out_valid  output  1  output pixel valid
out_ready  input  1  downstream ready
out_data  output  DATA_WIDTH  pixel
out_sof  output  1  first pixel of frame
out_eol  output  1  last pixel of a line
out_eof  output  1  last pixel of frame
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse; frame fully delivered
aborted  output  1  one-cycle pulse; frame ended by stop
cfg_err  output  1  one-cycle pulse; start rejected because cfg_width or cfg_height is 0
stall_cnt  output  STALL_WIDTH  saturating count of starved cycles; cleared on accepted start

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs and registers are 0, including out_data, flags, stall_cnt and counters.
- States:
  - IDLE: start with both dims nonzero -> RUN. Latch dims; clear col, row and stall_cnt. start with either dim 0 -> stay IDLE, pulse cfg_err next cycle.
  - RUN: pops pixels. When the pop of the last pixel (col=w-1, row=h-1) happens -> FLUSH.
  - FLUSH: no pops. When the output register is empty, or its pixel is accepted this cycle -> IDLE, with frame_done high for one cycle on entry to IDLE.
  - stop in RUN or FLUSH -> ABORT.
  - ABORT: no pops. The held output pixel, if any, is kept until accepted -> IDLE, with aborted pulsed on entry to IDLE. frame_done is not pulsed.
- Start/stop priority:
  - stop and start together in IDLE: stop wins; stay IDLE with no pulses.
  - start outside IDLE is ignored.
  - stop in IDLE is ignored.
- Pop rule: fifo_rd_en = (state==RUN) && !fifo_empty && (!out_valid || out_ready). Never pop when empty.
- Output register: one entry, 1-cycle latency. On a pop, at the next edge out_valid=1 and out_data=fifo_rd_data, with flags computed from the pre-increment col/row:
  - sof = (col==0 && row==0)
  - eol = (col==w-1)
  - eof = eol && (row==h-1)
- Output hold: out_valid/out_data/flags are held stable while out_valid && !out_ready. out_valid drops after acceptance when no new pop occurs that cycle.
- Full throughput: one pixel per cycle when the FIFO is non-empty and out_ready is continuously high.
- Counters: col increments per pop and wraps to 0 after w-1, at which point row increments. Unsigned DIM_WIDTH arithmetic; no wider intermediate needed.
- 1x1 frame: a single pixel carries sof, eol and eof together.
- stall_cnt: increments in RUN when fifo_empty && (!out_valid || out_ready). Saturates at all-ones.
- Latched dims are unaffected by cfg_* changes mid-frame.
- Reset asserted mid-frame returns to IDLE immediately; out_valid=0 and the pending pixel is lost.

Test Plan:
- w=4,h=2; FIFO preloaded with 0x10..0x17; out_ready=1 -> 8 consecutive beats, data 0x10..0x17:
  - sof on beat 0; eol on beats 3 and 7; eof on beat 7.
  - fifo_rd_en high for 8 cycles.
  - frame_done pulses once; busy falls the same cycle; stall_cnt=0.
- Same frame with out_ready toggling 1,0,1,0... -> data order preserved and each pixel held while out_ready=0. No pop occurs while out_valid && !out_ready; 8 pixels total.
- w=3,h=1 with the FIFO empty for 5 cycles after start, then 3 pixels written -> stall_cnt=5; output 3 beats with eof on the 3rd.
- start with cfg_width=0 -> cfg_err pulses; busy stays 0; no fifo_rd_en.
- w=8,h=8; stop after the 5th pop with out_ready=0 -> ABORT:
  - the held 5th pixel is delivered once out_ready=1.
  - aborted pulses and frame_done does not.
  - no further pops; FIFO retains the remaining pixels.
- w=1,h=1 back-to-back start pulses (a second start during RUN) -> exactly one beat with sof=eol=eof=1; the second start is ignored; one frame_done.
